// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the counter sequence checker and its bench.
package count_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PASS_COUNT = 5;

  // Bits needed to hold 0..pass_count inclusive.
  function automatic int run_cnt_w(input int pass_count);
    return (pass_count < 1) ? 1 : $clog2(pass_count + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sync reset, soft clear and a look-ahead next value.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a sampled counter stream increments by one (mod 2^WIDTH);
// one-cycle registered latency on all outputs, no backpressure (pure observer).
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PASS_COUNT = DEF_PASS_COUNT,
  parameter int ERR_CNT_W  = 8,
  parameter int ERR_LIMIT  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [WIDTH-1:0]                   in_val,
  input  logic                               clear,
  output logic                               locked,
  output logic                               pass,
  output logic                               err_pulse,
  output logic [ERR_CNT_W-1:0]               err_count,
  output logic [WIDTH-1:0]                   expected,
  output logic                               fault,
  output logic [run_cnt_w(PASS_COUNT)-1:0]   run_count
);

  localparam int RUN_W = run_cnt_w(PASS_COUNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             err_pulse_q, locked_q, pass_q, fault_q;

  logic                 sync_clr, anchor, hit, miss;
  logic [RUN_W-1:0]     run_next;
  logic [ERR_CNT_W-1:0] err_next;

  assign sync_clr = rst | clear;
  assign anchor   = en && (state_q == ST_IDLE);
  assign hit      = en && (state_q == ST_TRACK) && (in_val == expected_q);
  assign miss     = en && (state_q == ST_TRACK) && (in_val != expected_q);

  // Anchor and mismatch both restart the run of consecutive matches.
  sat_counter #(.WIDTH(RUN_W), .MAX(RUN_W'(PASS_COUNT))) u_run_cnt (
    .clk     (clk),
    .rst_i   (sync_clr),
    .clr_i   (anchor | miss),
    .inc_i   (hit),
    .count_o (run_count),
    .next_o  (run_next)
  );

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_i   (sync_clr),
    .clr_i   (1'b0),
    .inc_i   (miss),
    .count_o (err_count),
    .next_o  (err_next)
  );

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_TRACK;
          expected_d = in_val + WIDTH'(1);
        end
      end
      ST_TRACK: begin
        // A mismatch resyncs to the observed value rather than re-anchoring.
        if (en) begin
          expected_d = in_val + WIDTH'(1);
          if (miss && (err_next >= ERR_CNT_W'(ERR_LIMIT))) begin
            state_d = ST_FAULT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      state_q     <= ST_IDLE;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      pass_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      err_pulse_q <= miss;
      locked_q    <= (state_d == ST_TRACK);
      pass_q      <= (state_d == ST_TRACK) && (run_next == RUN_W'(PASS_COUNT));
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign locked    = locked_q;
  assign pass      = pass_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scenario and randomized bench for count_seq_checker against a behavioural model.
module tb_count_seq_checker;

  localparam int W    = 4;
  localparam int PASS = 5;
  localparam int ECW  = 8;
  localparam int LIM  = 3;
  localparam int MODV = 1 << W;
  localparam int EMAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   in_val = '0;
  logic           locked, pass, err_pulse, fault;
  logic [ECW-1:0] err_count;
  logic [W-1:0]   expected;
  logic [2:0]     run_count;

  int n_chk = 0;
  int n_fail = 0;

  // Model: 0 = idle, 1 = tracking, 2 = faulted
  int m_state, m_exp, m_run, m_err, m_pulse;

  count_seq_checker #(.WIDTH(W), .PASS_COUNT(PASS), .ERR_CNT_W(ECW), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .in_val(in_val), .clear(clear),
    .locked(locked), .pass(pass), .err_pulse(err_pulse), .err_count(err_count),
    .expected(expected), .fault(fault), .run_count(run_count)
  );

  always #5 clk = ~clk;

  // Applies one clock of stimulus and advances the model by the same sample.
  task automatic step(input bit r, input bit e, input bit c, input int v);
    rst = r; en = e; clear = c; in_val = W'(v);
    @(posedge clk);
    if (r || c) begin
      m_state = 0; m_exp = 0; m_run = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (e && m_state == 0) begin
        m_state = 1; m_exp = (v + 1) % MODV; m_run = 0;
      end else if (e && m_state == 1) begin
        if (v % MODV == m_exp) begin
          m_run = (m_run + 1 > PASS) ? PASS : m_run + 1;
        end else begin
          m_pulse = 1; m_run = 0;
          m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
          if (m_err >= LIM) m_state = 2;
        end
        m_exp = (v + 1) % MODV;
      end
    end
    #1;
    rst = 1'b0; clear = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 7);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%0b want=0", locked); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%0b want=0", pass); end
    n_chk++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got=%0b want=0", err_pulse); end
    n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    n_chk++; if (expected !== 4'd0) begin n_fail++; $display("FAIL reset_expected got=%0d want=0", expected); end
    n_chk++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%0b want=0", fault); end
    n_chk++; if (run_count !== 3'd0) begin n_fail++; $display("FAIL reset_run_count got=%0d want=0", run_count); end
  endtask

  task automatic test_pass();
    step(1, 0, 0, 0);
    for (int i = 0; i <= 5; i++) step(0, 1, 0, i);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pass_locked got=%0b want=1", locked); end
    n_chk++; if (run_count !== 3'd5) begin n_fail++; $display("FAIL pass_run_count got=%0d want=5", run_count); end
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL pass_pass got=%0b want=1", pass); end
    n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL pass_err_count got=%0d want=0", err_count); end
    n_chk++; if (expected !== 4'd6) begin n_fail++; $display("FAIL pass_expected got=%0d want=6", expected); end
  endtask

  task automatic test_wrap();
    int seq [6] = '{13, 14, 15, 0, 1, 2};
    step(1, 0, 0, 0);
    foreach (seq[i]) begin
      step(0, 1, 0, seq[i]);
      n_chk++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_err_pulse idx=%0d got=%0b want=0", i, err_pulse); end
    end
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL wrap_pass got=%0b want=1", pass); end
    n_chk++; if (expected !== 4'd3) begin n_fail++; $display("FAIL wrap_expected got=%0d want=3", expected); end
  endtask

  task automatic test_glitch();
    int seq [6] = '{0, 1, 2, 7, 8, 9};
    int want_pulse [6] = '{0, 0, 0, 1, 0, 0};
    step(1, 0, 0, 0);
    foreach (seq[i]) begin
      step(0, 1, 0, seq[i]);
      n_chk++; if (err_pulse !== want_pulse[i][0]) begin n_fail++; $display("FAIL glitch_err_pulse idx=%0d got=%0b want=%0d", i, err_pulse, want_pulse[i]); end
    end
    n_chk++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL glitch_err_count got=%0d want=1", err_count); end
    n_chk++; if (run_count !== 3'd2) begin n_fail++; $display("FAIL glitch_run_count got=%0d want=2", run_count); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL glitch_pass got=%0b want=0", pass); end
    n_chk++; if (expected !== 4'd10) begin n_fail++; $display("FAIL glitch_expected got=%0d want=10", expected); end
  endtask

  task automatic test_fault();
    int seq [4] = '{0, 5, 9, 3};
    step(1, 0, 0, 0);
    foreach (seq[i]) step(0, 1, 0, seq[i]);
    n_chk++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL fault_err_count got=%0d want=3", err_count); end
    n_chk++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_fault got=%0b want=1", fault); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL fault_locked got=%0b want=0", locked); end
    for (int v = 4; v <= 6; v++) begin
      step(0, 1, 0, v);
      n_chk++; if ({fault, locked, pass, err_pulse} !== 4'b1000) begin n_fail++; $display("FAIL fault_hold_flags v=%0d got=%b want=1000", v, {fault, locked, pass, err_pulse}); end
      n_chk++; if (err_count !== 8'd3 || expected !== 4'd4 || run_count !== 3'd0) begin n_fail++; $display("FAIL fault_hold_vals v=%0d got err=%0d exp=%0d run=%0d want 3 4 0", v, err_count, expected, run_count); end
    end
  endtask

  task automatic test_stall_gap();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, $urandom_range(0, 15));
      n_chk++; if (expected !== 4'd2 || run_count !== 3'd1 || locked !== 1'b1 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL gap_hold i=%0d got exp=%0d run=%0d lk=%0b ep=%0b want 2 1 1 0", i, expected, run_count, locked, err_pulse); end
    end
    step(0, 1, 0, 2);
    n_chk++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL stall_first got=%0b want=0", err_pulse); end
    step(0, 1, 0, 2);
    n_chk++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL stall_pulse got=%0b want=1", err_pulse); end
    n_chk++; if (expected !== 4'd3 || err_count !== 8'd1) begin n_fail++; $display("FAIL stall_vals got exp=%0d err=%0d want 3 1", expected, err_count); end
  endtask

  task automatic test_clear();
    test_pass();
    step(0, 1, 1, 6);
    n_chk++; if ({locked, pass, err_pulse, fault} !== 4'b0000 || err_count !== 8'd0 || expected !== 4'd0 || run_count !== 3'd0) begin n_fail++; $display("FAIL clear_outputs got lk=%0b ps=%0b ep=%0b ft=%0b err=%0d exp=%0d run=%0d want all 0", locked, pass, err_pulse, fault, err_count, expected, run_count); end
    step(0, 1, 0, 9);
    n_chk++; if (expected !== 4'd10 || locked !== 1'b1 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL clear_anchor got exp=%0d lk=%0b ep=%0b want 10 1 0", expected, locked, err_pulse); end
  endtask

  task automatic test_random();
    int v;
    step(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 99) < 80) ? m_exp : int'($urandom_range(0, MODV - 1));
      step(0, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3, v);
      n_chk++;
      if (locked !== (m_state == 1) || fault !== (m_state == 2) ||
          pass !== (m_state == 1 && m_run == PASS) || err_pulse !== m_pulse[0] ||
          err_count !== ECW'(m_err) || expected !== W'(m_exp) || run_count !== 3'(m_run)) begin
        n_fail++;
        $display("FAIL rand_cycle n=%0d got lk=%0b ft=%0b ps=%0b ep=%0b err=%0d exp=%0d run=%0d want st=%0d ep=%0d err=%0d exp=%0d run=%0d",
                 n, locked, fault, pass, err_pulse, err_count, expected, run_count, m_state, m_pulse, m_err, m_exp, m_run);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_wrap();
    test_glitch();
    test_fault();
    test_stall_gap();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Sequence monitor that sits on the output of a free-running WIDTH-bit up-counter and checks its value stream. It verifies that each sampled value equals the previous value plus one, modulo 2^WIDTH. It reports lock/pass status, per-error pulses, a saturating error count, and a sticky fault. It is the consuming end of the counter interface and is used both as an on-chip health monitor and as a reusable bench checker.

Parameters:
WIDTH, 4, width of the monitored count value
PASS_COUNT, 5, consecutive matched increments required to assert pass
ERR_CNT_W, 8, width of the error counter
ERR_LIMIT, 3, error_count value that forces the FAULT state (must be >=1 and <2^ERR_CNT_W)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en  in  1  sample strobe; in_val is checked on rising clk while en=1
in_val  in  WIDTH  observed counter value
clear  in  1  synchronous soft clear; same effect as rst
locked  out  1  high in TRACK state
pass  out  1  high while run_count == PASS_COUNT and not in FAULT
err_pulse  out  1  one-cycle pulse for each mismatched sample
err_count  out  ERR_CNT_W  total mismatches since reset/clear, saturating
expected  out  WIDTH  value the next sample must equal
fault  out  1  high in FAULT state
run_count  out  clog2(PASS_COUNT+1)  consecutive matches, saturating at PASS_COUNT

Behaviour:
- Reset: one clock, synchronous, active-high (rst); clear has identical effect. All outputs are registered.
- Reset/clear values: state=IDLE, locked=0, pass=0, err_pulse=0, err_count=0, expected=0, fault=0, run_count=0.
- rst/clear override everything, including a same-cycle en; that sample is discarded.
- States: IDLE, TRACK, FAULT.
- IDLE, en=1 (anchor sample):
  - expected <= in_val+1 mod 2^WIDTH; run_count <= 0; go to TRACK.
  - No error is possible on the anchor sample.
- TRACK, en=1, in_val == expected (match):
  - expected <= in_val+1; run_count <= min(run_count+1, PASS_COUNT).
- TRACK, en=1, mismatch:
  - err_pulse <= 1 for the next cycle only; err_count <= saturating +1.
  - run_count <= 0; expected <= in_val+1 (resync to the observed value, with no extra anchor cycle).
  - If the new err_count >= ERR_LIMIT, go to FAULT.
- Any state, en=0: no state, expected, or count change; err_pulse <= 0.
- FAULT:
  - Sticky until rst/clear; en is ignored; fault=1, locked=0, pass=0.
  - err_count and expected hold their values.
- Derived outputs:
  - pass = (state==TRACK) && (run_count==PASS_COUNT), registered with the same edge as run_count.
  - pass drops the cycle after any mismatch.
- Wrap-around: 2^WIDTH-1 followed by 0 is a match. All arithmetic is WIDTH-bit, truncating.
- A repeated value (stalled counter) is a mismatch.
- Latency: a sample on edge N is reflected in all outputs after edge N (visible in cycle N+1).
- err_count saturates at 2^ERR_CNT_W-1 and never wraps.

Decomposition:
- Shared package count_chk_pkg holds:
  - state enum (IDLE, TRACK, FAULT);
  - the run-count width function;
  - the default WIDTH and PASS_COUNT constants, shared with the counter bench.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturating output), instantiated for err_count and run_count.
- The FSM and compare logic stay in the top module.

Test Plan:
1. Reset 2 cycles, then en=1 with values 0,1,2,3,4,5 -> after the edge on 5: locked=1, run_count=5, pass=1, err_count=0, expected=6.
2. Wrap: anchor 13, then 14,15,0,1,2 -> pass=1, err_pulse never asserted, expected=3.
3. Glitch: 0,1,2,7,8,9 -> single err_pulse the cycle after 7 is sampled, err_count=1, run_count=2 after 9, pass=0, expected=10.
4. Fault: 0,5,9,3 (three mismatches, ERR_LIMIT=3) -> err_count=3, fault=1, locked=0; further samples 4,5,6 leave all outputs unchanged.
5. Stall and en gaps: 0,1 then en=0 for 4 cycles, then 2,2 -> no change during the gap, one err_pulse on the second 2, expected=3.
6. Clear mid-run: after scenario 1, assert clear together with en=1 and in_val=6 -> next cycle all outputs at reset values, state IDLE; the following sample 9 anchors with expected=10.
